hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 140 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Issue-stage RAW hazard scoreboard over a DEPTH-deep history of issued instructions.
// Optional: define HAZARD_R0_SKIP_EN so a slot writing R0 never matches.
module hazard_scoreboard #(
  parameter int DEPTH = 3,
  parameter int MODE  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  input  logic        flush,
  output logic        hazard,
  output logic [2:0]  hazard_slot,
  output logic [15:0] stall_count
);

  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_LHB  = 4'hA;
  localparam logic [3:0] OP_LLB  = 4'hB;
  localparam logic [3:0] OP_JAL  = 4'hD;
  localparam logic [3:0] OP_JR   = 4'hE;
  localparam logic [3:0] OP_EXEC = 4'hF;

  typedef struct packed {
    logic       wr;
    logic       ld;
    logic [3:0] rd;
  } slot_t;

  slot_t       hist_q [1:DEPTH];
  slot_t       hist_d [1:DEPTH];
  logic [15:0] stall_q, stall_d;

  slot_t        dec;
  logic [3:0]   op;
  logic [3:0]   src0, src1;
  logic         use0, use1;
  logic [DEPTH:1] hit;

  assign op = instr_in[15:12];

  always_comb begin
    dec    = '0;
    dec.rd = instr_in[11:8];
    src0   = instr_in[7:4];
    src1   = instr_in[3:0];
    use0   = 1'b0;
    use1   = 1'b0;
    unique case (1'b1)
      (op[3:2] == 2'b00): begin
        dec.wr = 1'b1;
        use0   = 1'b1;
        use1   = 1'b1;
      end
      (op[3:2] == 2'b01): begin
        dec.wr = 1'b1;
        use0   = 1'b1;
      end
      (op == OP_SW): begin
        src0 = instr_in[11:8];
        src1 = instr_in[7:4];
        use0 = 1'b1;
        use1 = 1'b1;
      end
      (op == OP_LW): begin
        dec.wr = 1'b1;
        dec.ld = 1'b1;
        use0   = 1'b1;
      end
      (op == OP_LHB), (op == OP_LLB): begin
        dec.wr = 1'b1;
        src0   = instr_in[11:8];
        use0   = 1'b1;
      end
      (op == OP_JR), (op == OP_EXEC): begin
        src0 = instr_in[11:8];
        use0 = 1'b1;
      end
      (op == OP_JAL): dec.wr = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    hit = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      hit[k] = hist_q[k].wr &&
               ((use0 && src0 == hist_q[k].rd) ||
                (use1 && src1 == hist_q[k].rd));
`ifdef HAZARD_R0_SKIP_EN
      // R0 is hardwired to zero, so its writer never blocks a reader
      if (hist_q[k].rd == 4'h0) hit[k] = 1'b0;
`endif
    end
  end

  always_comb begin
    hazard      = 1'b0;
    hazard_slot = 3'd0;
    if (rst && instr_valid) begin
      if (MODE == 0) begin
        for (int k = DEPTH; k >= 1; k--) begin
          if (hit[k]) begin
            hazard      = 1'b1;
            hazard_slot = 3'(k);
          end
        end
      end else if (hist_q[1].ld && hit[1]) begin
        hazard      = 1'b1;
        hazard_slot = 3'd1;
      end
    end
  end

  always_comb begin
    hist_d  = hist_q;
    stall_d = stall_q;
    if (flush) begin
      for (int k = 1; k <= DEPTH; k++) hist_d[k] = '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) hist_d[k] = hist_q[k-1];
      hist_d[1] = (instr_valid && !hazard) ? dec : '0;
      if (hazard && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= DEPTH; k++) hist_q[k] <= '0;
      stall_q <= '0;
    end else begin
      hist_q  <= hist_d;
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: MODE 0 and MODE 1 instances, directed
// scenarios plus random traffic checked against an instruction-level model.
module tb_hazard_scoreboard;

  localparam int D = 3;
  localparam logic [3:0] LW = 4'h8, SW = 4'h9, LHB = 4'hA, LLB = 4'hB;
  localparam logic [3:0] JAL = 4'hD, JR = 4'hE, EXEC = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr_in = '0;
  logic        instr_valid = 1'b0;
  logic        flush = 1'b0;
  logic        hz [2];
  logic [2:0]  hs [2];
  logic [15:0] sc [2];

  hazard_scoreboard #(.DEPTH(D), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .instr_in(instr_in),
    .instr_valid(instr_valid), .flush(flush),
    .hazard(hz[0]), .hazard_slot(hs[0]), .stall_count(sc[0]));

  hazard_scoreboard #(.DEPTH(D), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .instr_in(instr_in),
    .instr_valid(instr_valid), .flush(flush),
    .hazard(hz[1]), .hazard_slot(hs[1]), .stall_count(sc[1]));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model: raw instructions that entered history, slot 1 = most recent
  logic [15:0] m_ins [2][1:D];
  bit          m_v   [2][1:D];
  int          m_cnt [2];
  bit          e_h [2];
  int          e_s [2];
  logic        o_h [2];
  logic [2:0]  o_s [2];
  logic [15:0] o_c [2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit writes(input logic [15:0] i);
    logic [3:0] op = i[15:12];
    return op < 4'h8 || op == LW || op == LHB || op == LLB || op == JAL;
  endfunction

  function automatic bit reads(input logic [15:0] i, input logic [3:0] r);
    logic [3:0] op = i[15:12];
    if (op < 4'h4) return i[7:4] == r || i[3:0] == r;
    if (op < 4'h8) return i[7:4] == r;
    if (op == SW) return i[11:8] == r || i[7:4] == r;
    if (op == LW) return i[7:4] == r;
    if (op == LHB || op == LLB || op == JR || op == EXEC)
      return i[11:8] == r;
    return 1'b0;
  endfunction

  task automatic mdl(input int md, input logic [15:0] ins, input logic v,
                     output bit h, output int s);
    logic [3:0] d;
    h = 0;
    s = 0;
    if (!v) return;
    for (int k = 1; k <= D; k++) begin
      if (md == 1 && k > 1) break;
      if (!m_v[md][k] || !writes(m_ins[md][k])) continue;
      if (md == 1 && m_ins[md][k][15:12] != LW) continue;
      d = m_ins[md][k][11:8];
`ifdef HAZARD_R0_SKIP_EN
      if (d == 4'h0) continue;
`endif
      if (reads(ins, d)) begin
        h = 1;
        s = k;
        return;
      end
    end
  endtask

  task automatic mreset();
    for (int md = 0; md < 2; md++) begin
      for (int k = 1; k <= D; k++) begin
        m_v[md][k] = 0;
        m_ins[md][k] = '0;
      end
      m_cnt[md] = 0;
    end
  endtask

  task automatic step(input logic [15:0] ins, input logic v, input logic f);
    @(negedge clk);
    instr_in = ins;
    instr_valid = v;
    flush = f;
    #1;
    for (int md = 0; md < 2; md++) begin
      mdl(md, ins, v, e_h[md], e_s[md]);
      o_h[md] = hz[md];
      o_s[md] = hs[md];
      o_c[md] = sc[md];
      chk($sformatf("m%0d_hazard_%h", md, ins), 32'(o_h[md]), 32'(e_h[md]));
      chk($sformatf("m%0d_slot_%h", md, ins), 32'(o_s[md]), 32'(e_s[md]));
      chk($sformatf("m%0d_count", md), 32'(o_c[md]), 32'(m_cnt[md]));
    end
    @(posedge clk);
    for (int md = 0; md < 2; md++) begin
      if (f) begin
        for (int k = 1; k <= D; k++) m_v[md][k] = 0;
      end else begin
        for (int k = D; k >= 2; k--) begin
          m_v[md][k] = m_v[md][k-1];
          m_ins[md][k] = m_ins[md][k-1];
        end
        m_v[md][1] = v && !e_h[md];
        m_ins[md][1] = ins;
        if (e_h[md] && m_cnt[md] < 65535) m_cnt[md]++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(16'h0000, 1'b0, 1'b0);
  endtask

  function automatic logic [15:0] rnd_instr();
    logic [15:0] i;
    i[15:12] = 4'($urandom_range(0, 15));
    i[11:8]  = 4'($urandom_range(0, 3));
    i[7:4]   = 4'($urandom_range(0, 3));
    i[3:0]   = 4'($urandom_range(0, 3));
    return i;
  endfunction

  initial begin
    int c0;
    logic [15:0] ri;
    mreset();
    // reset state, with a live instruction presented
    instr_in = 16'h1415;
    instr_valid = 1'b1;
    #12;
    for (int md = 0; md < 2; md++) begin
      chk("reset_hazard", 32'(hz[md]), 32'd0);
      chk("reset_slot", 32'(hs[md]), 32'd0);
      chk("reset_count", 32'(sc[md]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    // ADD R1 then SUB reading R1: three-cycle stall in MODE 0
    step(16'h0123, 1, 0);
    for (int k = 1; k <= D; k++) begin
      step(16'h1415, 1, 0);
      chk("add_sub_hz", 32'(o_h[0]), 32'd1);
      chk("add_sub_slot", 32'(o_s[0]), 32'(k));
      chk("add_sub_m1_hz", 32'(o_h[1]), 32'd0);
    end
    step(16'h1415, 1, 0);
    chk("add_sub_push", 32'(o_h[0]), 32'd0);
    chk("add_sub_count", 32'(o_c[0]), 32'd3);
    idle(D);

    // load-use in MODE 1 is a single-cycle stall
    step(16'h8120, 1, 0);
    step(16'h1415, 1, 0);
    chk("lw_use_m1_hz", 32'(o_h[1]), 32'd1);
    chk("lw_use_m1_slot", 32'(o_s[1]), 32'd1);
    step(16'h1415, 1, 0);
    chk("lw_use_m1_clear", 32'(o_h[1]), 32'd0);
    step(16'h1415, 1, 0);
    step(16'h1415, 1, 0);
    idle(D);
    step(16'h0123, 1, 0);
    step(16'h1415, 1, 0);
    chk("add_use_m1_hz", 32'(o_h[1]), 32'd0);
    for (int i = 0; i < D; i++) step(16'h1415, 1, 0);
    idle(D);

    // flush squashes history and costs no stall
    step(16'h0123, 1, 0);
    c0 = int'(o_c[0]);
    step(16'h0000, 0, 1);
    step(16'h1415, 1, 0);
    chk("flush_hz", 32'(o_h[0]), 32'd0);
    chk("flush_count", 32'(o_c[0]), 32'(c0));
    idle(D);

    // store data register hazard, then an unrelated store
    step(16'h0123, 1, 0);
    step(16'h0000, 0, 0);
    step(16'h9120, 1, 0);
    chk("sw_hz", 32'(o_h[0]), 32'd1);
    chk("sw_slot", 32'(o_s[0]), 32'd2);
    step(16'h9120, 1, 0);
    step(16'h9120, 1, 0);
    step(16'h9670, 1, 0);
    chk("sw_unrel_hz", 32'(o_h[0]), 32'd0);
    idle(D);

    // writer of R0 followed by a reader of R0
    step(16'h0023, 1, 0);
    step(16'h1405, 1, 0);
`ifdef HAZARD_R0_SKIP_EN
    chk("r0_hz", 32'(o_h[0]), 32'd0);
`else
    chk("r0_hz", 32'(o_h[0]), 32'd1);
`endif
    for (int i = 0; i < D; i++) step(16'h1405, 1, 0);
    idle(D);

    // reset asserted in the second stall cycle
    step(16'h0123, 1, 0);
    step(16'h1415, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_hz", 32'(hz[0]), 32'd0);
    chk("rst_mid_slot", 32'(hs[0]), 32'd0);
    chk("rst_mid_count", 32'(sc[0]), 32'd0);
    mreset();
    @(negedge clk);
    rst = 1'b1;
    step(16'h1415, 1, 0);
    chk("rst_after_hz", 32'(o_h[0]), 32'd0);
    idle(D);

    // random traffic; the issue stage usually holds a stalled instruction
    ri = rnd_instr();
    for (int n = 0; n < 400; n++) begin
      if (!(e_h[0] && $urandom_range(0, 3) != 0)) ri = rnd_instr();
      step(ri, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
